// File: rtl/axis_vote_pkg.sv
// Shared definitions for the N-way AXI-Stream voter: tuser bit positions,
// output-register state encoding and the vote-count width helper.
package axis_vote_pkg;

   localparam int TUSER_NO_MAJ        = 0;
   localparam int TUSER_LAST_MISMATCH = 1;
   localparam int TUSER_W             = 2;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_t;

   function automatic int vote_count_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/axis_vote_fifo.sv
// Per-channel synchronous FIFO holding {tlast, tdata}; flags come from the
// registered pointers so ready never depends on the same-cycle pop.
module axis_vote_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                push,
   input  logic [DATA_WIDTH:0] wdata,
   input  logic                pop,
   output logic [DATA_WIDTH:0] rdata,
   output logic                full,
   output logic                empty
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
   logic [AW:0]         wr_ptr;
   logic [AW:0]         rd_ptr;
   logic                do_push;
   logic                do_pop;

   // The extra pointer bit separates full (MSBs differ) from empty (equal).
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/axis_nway_vote.sv
// N-input AXI-Stream majority voter with per-channel FIFOs and a registered output.
// Optional statistics block enabled by defining VOTE_STATS_EN.
module axis_nway_vote
   import axis_vote_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_CH     = 3,
   parameter int FIFO_DEPTH = 4,
   parameter int THRESHOLD  = NUM_CH / 2 + 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
`ifdef VOTE_STATS_EN
   input  logic                         stat_clr,
   output logic [31:0]                  stat_words,
   output logic [31:0]                  stat_no_majority,
   output logic [NUM_CH-1:0]            stat_ch_fault,
`endif
   input  logic [NUM_CH*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [NUM_CH-1:0]            s_axis_tvalid,
   output logic [NUM_CH-1:0]            s_axis_tready,
   input  logic [NUM_CH-1:0]            s_axis_tlast,
   output logic [DATA_WIDTH-1:0]        m_axis_tdata,
   output logic                         m_axis_tvalid,
   input  logic                         m_axis_tready,
   output logic                         m_axis_tlast,
   output logic [TUSER_W-1:0]           m_axis_tuser
);

   localparam int CW = vote_count_w(NUM_CH);
   localparam int IW = $clog2(NUM_CH);
   localparam logic [CW-1:0] THR = CW'(THRESHOLD);

   logic [NUM_CH-1:0]     full;
   logic [NUM_CH-1:0]     empty;
   logic [DATA_WIDTH:0]   rd_p0   [NUM_CH];
   logic [DATA_WIDTH-1:0] data_p0 [NUM_CH];
   logic [NUM_CH-1:0]     last_p0;
   logic                  fire;

   logic [CW-1:0]         cnt_p0 [NUM_CH];
   logic [CW-1:0]         best_cnt_p0;
   logic [IW-1:0]         win_p0;
   logic [DATA_WIDTH-1:0] win_data_p0;
   logic [TUSER_W-1:0]    user_p0;

   out_state_t            state;
   out_state_t            state_nxt;
   logic                  vld_p1;
   logic [DATA_WIDTH-1:0] data_p1;
   logic                  last_p1;
   logic [TUSER_W-1:0]    user_p1;

   // Stage p0: per-channel buffering and FIFO heads
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      axis_vote_fifo #(
         .DATA_WIDTH (DATA_WIDTH),
         .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst_n (rst_n),
         .push  (s_axis_tvalid[g]),
         .wdata ({s_axis_tlast[g], s_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH]}),
         .pop   (fire),
         .rdata (rd_p0[g]),
         .full  (full[g]),
         .empty (empty[g])
      );
      assign data_p0[g] = rd_p0[g][DATA_WIDTH-1:0];
      assign last_p0[g] = rd_p0[g][DATA_WIDTH];
   end

   assign s_axis_tready = ~full;
   assign fire          = !(|empty) && (!vld_p1 || m_axis_tready);

   // Strict '>' keeps the lowest index among equally popular values.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_p0[i] = '0;
         for (int j = 0; j < NUM_CH; j++) begin
            if (data_p0[j] == data_p0[i]) cnt_p0[i] = cnt_p0[i] + CW'(1);
         end
      end
      win_p0      = '0;
      best_cnt_p0 = cnt_p0[0];
      for (int i = 1; i < NUM_CH; i++) begin
         if (cnt_p0[i] > best_cnt_p0) begin
            best_cnt_p0 = cnt_p0[i];
            win_p0      = IW'(i);
         end
      end
   end

   assign win_data_p0 = data_p0[win_p0];

   always_comb begin
      user_p0                      = '0;
      user_p0[TUSER_NO_MAJ]        = (best_cnt_p0 < THR);
      user_p0[TUSER_LAST_MISMATCH] = (|last_p0) && !(&last_p0);
   end

   // Stage p1: output register and its occupancy state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY: if (fire) state_nxt = FULL;
         FULL:  if (!fire && m_axis_tready) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   assign vld_p1 = (state == FULL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_p1 <= '0;
         last_p1 <= 1'b0;
         user_p1 <= '0;
      end else if (fire) begin
         data_p1 <= win_data_p0;
         last_p1 <= &last_p0;
         user_p1 <= user_p0;
      end
   end

   assign m_axis_tvalid = vld_p1;
   assign m_axis_tdata  = data_p1;
   assign m_axis_tlast  = last_p1;
   assign m_axis_tuser  = user_p1;

`ifdef VOTE_STATS_EN
   logic [NUM_CH-1:0] dissent_p0;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) dissent_p0[i] = (data_p0[i] != win_data_p0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_words       <= '0;
         stat_no_majority <= '0;
         stat_ch_fault    <= '0;
      end else if (stat_clr) begin
         stat_words       <= '0;
         stat_no_majority <= '0;
         stat_ch_fault    <= '0;
      end else if (fire) begin
         stat_words    <= stat_words + 32'd1;
         stat_ch_fault <= stat_ch_fault | dissent_p0;
         if (user_p0[TUSER_NO_MAJ]) stat_no_majority <= stat_no_majority + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_axis_nway_vote.sv
// Directed self-checking bench for axis_nway_vote (3 channels, depth 4);
// statistics checks are included when VOTE_STATS_EN is defined.
module tb_axis_nway_vote;

   localparam int DW = 32;
   localparam int NC = 3;
   localparam int FD = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [NC*DW-1:0] s_tdata;
   logic [NC-1:0]  s_tvalid;
   logic [NC-1:0]  s_tready;
   logic [NC-1:0]  s_tlast;
   logic [DW-1:0]  m_tdata;
   logic           m_tvalid;
   logic           m_tready;
   logic           m_tlast;
   logic [1:0]     m_tuser;
`ifdef VOTE_STATS_EN
   logic           stat_clr;
   logic [31:0]    stat_words;
   logic [31:0]    stat_no_majority;
   logic [NC-1:0]  stat_ch_fault;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   axis_nway_vote #(
      .DATA_WIDTH (DW),
      .NUM_CH     (NC),
      .FIFO_DEPTH (FD),
      .THRESHOLD  (NC / 2 + 1)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
`ifdef VOTE_STATS_EN
      .stat_clr         (stat_clr),
      .stat_words       (stat_words),
      .stat_no_majority (stat_no_majority),
      .stat_ch_fault    (stat_ch_fault),
`endif
      .s_axis_tdata     (s_tdata),
      .s_axis_tvalid    (s_tvalid),
      .s_axis_tready    (s_tready),
      .s_axis_tlast     (s_tlast),
      .m_axis_tdata     (m_tdata),
      .m_axis_tvalid    (m_tvalid),
      .m_axis_tready    (m_tready),
      .m_axis_tlast     (m_tlast),
      .m_axis_tuser     (m_tuser)
   );

   // One-cycle handshake on the selected channels; caller ensures readies are high.
   task automatic push_set(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                           input logic [DW-1:0] d2, input logic [2:0] l, input logic [2:0] v);
      s_tdata  = {d2, d1, d0};
      s_tlast  = l;
      s_tvalid = v;
      @(posedge clk); #1;
      s_tvalid = '0;
   endtask

   task automatic test_reset;
      rst_n    = 1'b0;
      s_tvalid = '0;
      s_tdata  = '0;
      s_tlast  = '0;
      m_tready = 1'b0;
`ifdef VOTE_STATS_EN
      stat_clr = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (s_tready !== 3'b111) begin
         failures++; $display("FAIL reset_tready got=%b exp=111", s_tready);
      end
      checks++;
      if ({m_tvalid, m_tlast, m_tuser, m_tdata} !== 36'h0) begin
         failures++; $display("FAIL reset_out got=%h exp=0", {m_tvalid, m_tlast, m_tuser, m_tdata});
      end
`ifdef VOTE_STATS_EN
      checks++;
      if ({stat_words, stat_no_majority, stat_ch_fault} !== '0) begin
         failures++; $display("FAIL reset_stats got=%h exp=0", {stat_words, stat_no_majority, stat_ch_fault});
      end
`endif
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (m_tvalid !== 1'b0) begin
         failures++; $display("FAIL reset_release_valid got=%b exp=0", m_tvalid);
      end
   endtask

   task automatic test_unanimous;
      m_tready = 1'b1;
      push_set(32'hA5, 32'hA5, 32'hA5, 3'b111, 3'b111);
      checks++;
      if (m_tvalid !== 1'b0) begin
         failures++; $display("FAIL unan_latency_c1 got=%b exp=0", m_tvalid);
      end
      @(posedge clk); #1;
      checks++;
      if ({m_tvalid, m_tlast, m_tuser, m_tdata} !== {1'b1, 1'b1, 2'b00, 32'h0000_00A5}) begin
         failures++; $display("FAIL unan_out got=%h exp=%h", {m_tvalid, m_tlast, m_tuser, m_tdata},
                              {1'b1, 1'b1, 2'b00, 32'h0000_00A5});
      end
      @(posedge clk); #1;
      checks++;
      if (m_tvalid !== 1'b0) begin
         failures++; $display("FAIL unan_drain got=%b exp=0", m_tvalid);
      end
   endtask

   task automatic test_outvote;
`ifdef VOTE_STATS_EN
      stat_clr = 1'b1;
      @(posedge clk); #1;
      stat_clr = 1'b0;
`endif
      m_tready = 1'b1;
      push_set(32'h11, 32'h22, 32'h11, 3'b000, 3'b111);
      @(posedge clk); #1;
      checks++;
      if ({m_tvalid, m_tlast, m_tuser, m_tdata} !== {1'b1, 1'b0, 2'b00, 32'h11}) begin
         failures++; $display("FAIL outvote_out got=%h exp=%h", {m_tvalid, m_tlast, m_tuser, m_tdata},
                              {1'b1, 1'b0, 2'b00, 32'h11});
      end
`ifdef VOTE_STATS_EN
      checks++;
      if (stat_ch_fault !== 3'b010) begin
         failures++; $display("FAIL outvote_fault got=%b exp=010", stat_ch_fault);
      end
      checks++;
      if (stat_words !== 32'd1) begin
         failures++; $display("FAIL outvote_words got=%0d exp=1", stat_words);
      end
`endif
      @(posedge clk); #1;
   endtask

   task automatic test_no_majority;
`ifdef VOTE_STATS_EN
      logic [31:0] nm0;
      nm0 = stat_no_majority;
`endif
      m_tready = 1'b1;
      push_set(32'h1, 32'h2, 32'h3, 3'b111, 3'b111);
      @(posedge clk); #1;
      checks++;
      if ({m_tvalid, m_tlast, m_tuser, m_tdata} !== {1'b1, 1'b1, 2'b01, 32'h1}) begin
         failures++; $display("FAIL nomaj_out got=%h exp=%h", {m_tvalid, m_tlast, m_tuser, m_tdata},
                              {1'b1, 1'b1, 2'b01, 32'h1});
      end
`ifdef VOTE_STATS_EN
      checks++;
      if (stat_no_majority !== nm0 + 32'd1) begin
         failures++; $display("FAIL nomaj_stat got=%0d exp=%0d", stat_no_majority, nm0 + 32'd1);
      end
`endif
      @(posedge clk); #1;
   endtask

   task automatic test_tlast_mismatch;
      m_tready = 1'b1;
      push_set(32'h55, 32'h55, 32'h55, 3'b011, 3'b111);
      @(posedge clk); #1;
      checks++;
      if ({m_tvalid, m_tlast, m_tuser, m_tdata} !== {1'b1, 1'b0, 2'b10, 32'h55}) begin
         failures++; $display("FAIL lastmis_out got=%h exp=%h", {m_tvalid, m_tlast, m_tuser, m_tdata},
                              {1'b1, 1'b0, 2'b10, 32'h55});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      logic [DW-1:0] d;
      logic [DW-1:0] e;
      m_tready = 1'b1;
      for (int cyc = 0; cyc < 8; cyc++) begin
         if (cyc < 4) begin
            d        = 32'h200 + 32'(cyc);
            s_tdata  = {d, d, d};
            s_tlast  = '0;
            s_tvalid = 3'b111;
         end else begin
            s_tvalid = '0;
         end
         if (cyc >= 2 && cyc < 6) begin
            e = 32'h200 + 32'(cyc - 2);
            checks++;
            if ({m_tvalid, m_tdata} !== {1'b1, e}) begin
               failures++; $display("FAIL b2b_out cyc=%0d got=%h exp=%h", cyc, {m_tvalid, m_tdata}, {1'b1, e});
            end
         end else if (cyc >= 6) begin
            checks++;
            if (m_tvalid !== 1'b0) begin
               failures++; $display("FAIL b2b_idle cyc=%0d got=%b exp=0", cyc, m_tvalid);
            end
         end
         checks++;
         if (s_tready !== 3'b111) begin
            failures++; $display("FAIL b2b_ready cyc=%0d got=%b exp=111", cyc, s_tready);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_skew_backpressure;
      int            idx [NC];
      int            nout;
      int            cyc;
      logic          held_v;
      logic [DW-1:0] held_d;
      logic [NC-1:0] hs;
      logic [DW-1:0] e;
      idx    = '{0, 0, 0};
      nout   = 0;
      cyc    = 0;
      held_v = 1'b0;
      held_d = '0;
      while (nout < 6 && cyc < 60) begin
         if (cyc == 4) begin
            checks++;
            if (idx[0] != 4 || idx[1] != 4 || idx[2] != 0 || s_tready !== 3'b100 || m_tvalid !== 1'b0) begin
               failures++; $display("FAIL skew_full got idx=%0d/%0d/%0d ready=%b vld=%b exp idx=4/4/0 ready=100 vld=0",
                                    idx[0], idx[1], idx[2], s_tready, m_tvalid);
            end
         end
         for (int ch = 0; ch < NC; ch++) begin
            s_tvalid[ch]              = (idx[ch] < 6) && (ch != 2 || cyc >= 4);
            s_tdata[ch*DW +: DW]      = 32'h100 + 32'(idx[ch]);
            s_tlast[ch]               = (idx[ch] == 5);
         end
         m_tready = (cyc >= 10);
         hs       = s_tvalid & s_tready;
         if (m_tvalid && m_tready) begin
            e = 32'h100 + 32'(nout);
            checks++;
            if ({m_tlast, m_tuser, m_tdata} !== {(nout == 5), 2'b00, e}) begin
               failures++; $display("FAIL skew_out n=%0d got=%h exp=%h", nout, {m_tlast, m_tuser, m_tdata},
                                    {(nout == 5), 2'b00, e});
            end
            nout++;
            held_v = 1'b0;
         end else if (m_tvalid) begin
            if (held_v) begin
               checks++;
               if (m_tdata !== held_d) begin
                  failures++; $display("FAIL skew_stall cyc=%0d got=%h exp=%h", cyc, m_tdata, held_d);
               end
            end
            held_v = 1'b1;
            held_d = m_tdata;
         end
         @(posedge clk); #1;
         for (int ch = 0; ch < NC; ch++) if (hs[ch]) idx[ch]++;
         cyc++;
      end
      s_tvalid = '0;
      checks++;
      if (nout != 6) begin
         failures++; $display("FAIL skew_count got=%0d exp=6 (cycle budget expired)", nout);
      end
      checks++;
      if (m_tvalid !== 1'b0 || s_tready !== 3'b111) begin
         failures++; $display("FAIL skew_end got vld=%b ready=%b exp vld=0 ready=111", m_tvalid, s_tready);
      end
   endtask

   task automatic test_reset_mid;
      m_tready = 1'b0;
      push_set(32'hAA, 32'hAA, 32'hAA, 3'b111, 3'b111);
      push_set(32'hBB, 32'hBB, 32'h0, 3'b000, 3'b011);
      push_set(32'hCC, 32'hCC, 32'h0, 3'b000, 3'b011);
      checks++;
      if ({m_tvalid, m_tdata} !== {1'b1, 32'hAA}) begin
         failures++; $display("FAIL rstmid_pre got=%h exp=%h", {m_tvalid, m_tdata}, {1'b1, 32'hAA});
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({m_tvalid, m_tlast, m_tuser, m_tdata} !== 36'h0) begin
         failures++; $display("FAIL rstmid_out got=%h exp=0", {m_tvalid, m_tlast, m_tuser, m_tdata});
      end
      checks++;
      if (s_tready !== 3'b111) begin
         failures++; $display("FAIL rstmid_ready got=%b exp=111", s_tready);
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      m_tready = 1'b1;
      push_set(32'h0, 32'h0, 32'h66, 3'b000, 3'b100);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (m_tvalid !== 1'b0) begin
            failures++; $display("FAIL rstmid_stale k=%0d got vld=%b data=%h exp vld=0", k, m_tvalid, m_tdata);
         end
         @(posedge clk); #1;
      end
      push_set(32'h66, 32'h66, 32'h0, 3'b000, 3'b011);
      @(posedge clk); #1;
      checks++;
      if ({m_tvalid, m_tlast, m_tuser, m_tdata} !== {1'b1, 1'b0, 2'b00, 32'h66}) begin
         failures++; $display("FAIL rstmid_fresh got=%h exp=%h", {m_tvalid, m_tlast, m_tuser, m_tdata},
                              {1'b1, 1'b0, 2'b00, 32'h66});
      end
      @(posedge clk); #1;
      checks++;
      if (m_tvalid !== 1'b0) begin
         failures++; $display("FAIL rstmid_drain got=%b exp=0", m_tvalid);
      end
   endtask

   initial begin
      test_reset();
      test_unanimous();
      test_outvote();
      test_no_majority();
      test_tlast_mismatch();
      test_back_to_back();
      test_skew_backpressure();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "simulation time limit reached");
   end

endmodule
